// File: rtl/fsm_pkg.sv
// fsm_pkg: shared state encodings and width helper for the serial FSM blocks
package fsm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial stage with valid/ready load and zero-bubble reload
// Define BIT_SERIALIZER_LOOP_EN to recirculate the last accepted word instead of going idle
module bit_serializer
    import fsm_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = clog2w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [CNT_W-1:0] bit_idx,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_accept;
`ifdef BIT_SERIALIZER_LOOP_EN
    logic [WIDTH-1:0] r_wsave;
`endif

    assign w_last     = (r_cnt == '0);
    assign load_ready = (r_state == ST_IDLE) | ((r_state == ST_SHIFT) & w_last);
    assign w_accept   = load_valid & load_ready;
    assign bit_out    = r_shreg[WIDTH-1];
    assign bit_valid  = (r_state == ST_SHIFT);
    assign busy       = (r_state == ST_SHIFT);
    assign bit_idx    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
`ifdef BIT_SERIALIZER_LOOP_EN
            r_wsave <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_shreg <= load_data;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                    end
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_cnt   <= r_cnt - 1'b1;
                    end else if (w_accept) begin
                        r_shreg <= load_data;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                    end else begin
`ifdef BIT_SERIALIZER_LOOP_EN
                        r_shreg <= r_wsave;
                        r_cnt   <= CNT_W'(WIDTH - 1);
`else
                        r_state <= ST_IDLE;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef BIT_SERIALIZER_LOOP_EN
            if (w_accept) r_wsave <= load_data;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized checks of bit_serializer against a queue-of-bits reference model
module tb_bit_serializer;

    localparam int W  = 16;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          load_ready, bit_out, bit_valid, busy;
    logic [CW-1:0] bit_idx;

    int total = 0;
    int bad = 0;

    bit           q[$];
    bit           last_out = 1'b0;
    logic [W-1:0] saved = '0;
    bit           acc = 1'b0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_idx(bit_idx), .busy(busy)
    );

    a_valid_busy: assert property (@(posedge clk) bit_valid == busy);
    a_cnt_range:  assert property (@(posedge clk) bit_idx <= CW'(W - 1));

    // Model: q holds the bits still to be shown, front = bit on the wire now
    function automatic bit e_ready(); return q.size() <= 1; endfunction
    function automatic bit e_valid(); return q.size() > 0; endfunction
    function automatic bit e_out(); return (q.size() > 0) ? q[0] : last_out; endfunction
    function automatic logic [CW-1:0] e_idx(); return (q.size() > 0) ? CW'(q.size() - 1) : '0; endfunction

    task automatic m_reset();
        q.delete();
        last_out = 1'b0;
        saved = '0;
    endtask

    task automatic m_fill(input logic [W-1:0] w);
        q.delete();
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        acc = 1'b0;
        if (!rst_n) m_reset();
        else begin
            if (q.size() > 0) last_out = q[0];
            if (load_valid && e_ready()) begin
                acc = 1'b1;
                saved = load_data;
                m_fill(load_data);
            end else if (q.size() == 1) begin
`ifdef BIT_SERIALIZER_LOOP_EN
                m_fill(saved);
`else
                void'(q.pop_front());
`endif
            end else if (q.size() > 1) void'(q.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) rst_n = 1'b1;
            tick();
            total++;
            if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {1'b0, 1'b0, 1'b0, 1'b1, CW'(0)}) begin
                bad++;
                $display("FAIL reset c=%0d got v=%b b=%b o=%b r=%b i=%0d want v=0 b=0 o=0 r=1 i=0",
                         c, bit_valid, busy, bit_out, load_ready, bit_idx);
            end
        end
    endtask

    task automatic test_single();
        int nvalid = 0, det = 0, nb = 0;
        logic [3:0] sh = '0;
        load_data = 16'b1000_1001_1001_1101;
        load_valid = 1'b1;
        for (int c = 0; c < 21; c++) begin
            tick();
            if (c == 0) begin
                load_valid = 1'b0;
                load_data = W'($urandom);
            end
            total++;
            if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {e_valid(), e_valid(), e_out(), e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL single c=%0d got v=%b b=%b o=%b r=%b i=%0d want v=%b o=%b r=%b i=%0d",
                         c, bit_valid, busy, bit_out, load_ready, bit_idx, e_valid(), e_out(), e_ready(), e_idx());
            end
            if (bit_valid) begin
                nvalid++;
                nb++;
                sh = {sh[2:0], bit_out};
                if (nb >= 4 && sh == 4'b1001) det++;
            end
        end
        total++;
        if (nvalid != 16) begin bad++; $display("FAIL single_len got=%0d want=16", nvalid); end
        total++;
        if (det != 2) begin bad++; $display("FAIL single_1001 got=%0d want=2", det); end
    endtask

    task automatic test_back_to_back();
        int nacc = 0, nvalid = 0;
        load_data = 16'hA5A5;
        load_valid = 1'b1;
        for (int c = 0; c < 36; c++) begin
            tick();
            if (acc) begin
                nacc++;
                if (nacc == 1) load_data = 16'hFFFF;
                else load_valid = 1'b0;
            end
            total++;
            if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {e_valid(), e_valid(), e_out(), e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL b2b c=%0d got v=%b b=%b o=%b r=%b i=%0d want v=%b o=%b r=%b i=%0d",
                         c, bit_valid, busy, bit_out, load_ready, bit_idx, e_valid(), e_out(), e_ready(), e_idx());
            end
            if (bit_valid) nvalid++;
        end
        total++;
        if (nvalid != 32 || nacc != 2) begin
            bad++;
            $display("FAIL b2b_run got valid=%0d acc=%0d want valid=32 acc=2", nvalid, nacc);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] w1, w2, got;
        int nb = 0, c = 0;
        bit seen7 = 1'b0;
        w1 = W'($urandom);
        w2 = W'($urandom);
        got = '0;
        load_data = w1;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        while (c < 60 && !(acc && seen7)) begin
            if (bit_valid && nb < W) begin got = {got[W-2:0], bit_out}; nb++; end
            total++;
            if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {e_valid(), e_valid(), e_out(), e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL stall c=%0d got v=%b b=%b o=%b r=%b i=%0d want v=%b o=%b r=%b i=%0d",
                         c, bit_valid, busy, bit_out, load_ready, bit_idx, e_valid(), e_out(), e_ready(), e_idx());
            end
            if (!seen7 && e_idx() == CW'(7)) begin
                seen7 = 1'b1;
                load_data = w2;
                load_valid = 1'b1;
                total++;
                if (load_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", load_ready); end
            end
            tick();
            c++;
        end
        load_valid = 1'b0;
        total++;
        if (!(acc && seen7)) begin bad++; $display("FAIL stall_timeout got acc=%b want acc=1", acc); end
        total++;
        if (got !== w1 || nb != W) begin bad++; $display("FAIL stall_word got=%h want=%h", got, w1); end
        for (int k = 0; k < 18; k++) begin
            tick();
            total++;
            if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {e_valid(), e_valid(), e_out(), e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL stall_tail k=%0d got v=%b o=%b r=%b i=%0d want v=%b o=%b r=%b i=%0d",
                         k, bit_valid, bit_out, load_ready, bit_idx, e_valid(), e_out(), e_ready(), e_idx());
            end
        end
    endtask

    task automatic test_reset_mid();
        load_data = 16'hF0F0;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        total++;
        if (bit_valid !== 1'b1 || bit_idx !== CW'(11)) begin
            bad++;
            $display("FAIL mid_pre got v=%b i=%0d want v=1 i=11", bit_valid, bit_idx);
        end
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        total++;
        if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {1'b0, 1'b0, 1'b0, 1'b1, CW'(0)}) begin
            bad++;
            $display("FAIL mid_async got v=%b b=%b o=%b r=%b i=%0d want v=0 b=0 o=0 r=1 i=0",
                     bit_valid, busy, bit_out, load_ready, bit_idx);
        end
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst_n = 1'b1;
            tick();
            total++;
            if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {e_valid(), e_valid(), e_out(), e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL mid_after k=%0d got v=%b o=%b r=%b i=%0d want v=%b o=%b r=%b i=%0d",
                         k, bit_valid, bit_out, load_ready, bit_idx, e_valid(), e_out(), e_ready(), e_idx());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data = W'($urandom);
            tick();
            total++;
            if ({bit_valid, busy, bit_out, load_ready, bit_idx} !== {e_valid(), e_valid(), e_out(), e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL random c=%0d got v=%b o=%b r=%b i=%0d want v=%b o=%b r=%b i=%0d",
                         c, bit_valid, bit_out, load_ready, bit_idx, e_valid(), e_out(), e_ready(), e_idx());
            end
        end
        load_valid = 1'b0;
        for (int c = 0; c < 20; c++) tick();
    endtask

`ifdef BIT_SERIALIZER_LOOP_EN
    task automatic test_loop();
        bit bits[$];
        int c = 0;
        load_data = 16'h8001;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 52; k++) begin
            bits.push_back(bit_out);
            total++;
            if ({bit_valid, bit_out, load_ready, bit_idx} !== {e_valid(), e_out(), e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL loop k=%0d got v=%b o=%b r=%b i=%0d want v=%b o=%b r=%b i=%0d",
                         k, bit_valid, bit_out, load_ready, bit_idx, e_valid(), e_out(), e_ready(), e_idx());
            end
            tick();
        end
        for (int k = 0; k + W < bits.size(); k++) begin
            total++;
            if (bits[k] !== bits[k + W]) begin bad++; $display("FAIL loop_period k=%0d got=%b want=%b", k, bits[k + W], bits[k]); end
        end
        while (c < 20 && e_idx() != '0) begin tick(); c++; end
        load_data = 16'h0000;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            total++;
            if ({bit_valid, bit_out, load_ready, bit_idx} !== {1'b1, 1'b0, e_ready(), e_idx()}) begin
                bad++;
                $display("FAIL loop_replace k=%0d got v=%b o=%b r=%b i=%0d want v=1 o=0 r=%b i=%0d",
                         k, bit_valid, bit_out, load_ready, bit_idx, e_ready(), e_idx());
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef BIT_SERIALIZER_LOOP_EN
        test_loop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
